uart_boot_loader: RTL and testbench
===================================

# uart_boot_loader

Boot-time program loader sitting between the UART receiver and the instruction memory of the RISC-V core. It parses a framed byte stream from the receiver (sync, word count, little-endian 32-bit words, XOR checksum) and writes each word into memory through a request/acknowledge port. It holds the CPU in reset until a frame completes with a valid checksum. Any framing fault or byte timeout raises a sticky error flag.

## Interface
- `ADDR_W`, 12: word-address width of the memory port; maximum load is 2^ADDR_W words.
- `BASE_ADDR`, 0: word address of the first loaded word.
- `SYNC_BYTE`, 8'h55: frame start byte.
- `TIMEOUT`, 1_000_000: maximum number of clk cycles allowed between bytes once a frame has started.

- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `rx_byte`, in, 8: received byte. Valid only when `rx_valid`=1.
- `rx_valid`, in, 1: single-cycle pulse per received byte (the receiver's done tick).
- `mem_req`, out, 1: write request.
- `mem_ack`, in, 1: memory accepted the write. Sampled only while `mem_req`=1.
- `mem_addr`, out, ADDR_W: word address of the write.
- `mem_wdata`, out, 32: write data.
- `cpu_hold`, out, 1: 1 keeps the CPU in reset.
- `busy`, out, 1: a frame is in progress.
- `done`, out, 1: the last frame loaded correctly.
- `error`, out, 1: the last frame failed.

## Operation
- **Frame format:** `SYNC_BYTE`, LEN_LO, LEN_HI, then LEN×4 data bytes (least-significant byte first per word), then CHK. CHK = XOR of LEN_LO, LEN_HI and all data bytes.
- **States and transitions:**
  - IDLE → LEN_LO on `rx_byte`==`SYNC_BYTE`. Other bytes are ignored.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI:
    - if LEN > 2^ADDR_W → ERR;
    - if LEN==0 → CHK;
    - otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register, byte k into bits [8k+7:8k]. On the 4th byte → WRITE.
  - WRITE: hold `mem_req`=1 until `mem_ack`. Then go to DATA if words remain, else to CHK.
  - CHK: byte equal to the running XOR → DONE; otherwise → ERR.
  - DONE: `done`=1, `cpu_hold`=0.
  - ERR: `error`=1, `cpu_hold`=1.
  - From DONE or ERR, a `SYNC_BYTE` restarts a frame. On restart, clear `done`/`error`, set `cpu_hold`=1, reset the XOR to 0 and the word index to 0.
- **Addressing:** `mem_addr` = `BASE_ADDR` + word index, modulo 2^ADDR_W. The index increments on each acknowledged write.
- **Byte during WRITE:** a byte arriving while in WRITE is captured in a one-entry pending register and consumed the cycle after the ack. A second byte arriving while pending is full → ERR (overrun).
- **Timeout:** an inter-byte counter runs in every state except IDLE, DONE and ERR. It clears on each `rx_valid`. If it reaches `TIMEOUT` → ERR. The counter is frozen while waiting for `mem_ack` only if a byte is pending.
- **Partial writes:** words already written before an error are not rolled back.
- **Reset:** asynchronous reset returns to IDLE from any state, including mid-write. `mem_req` drops immediately.

## Timing
- **Reset values:**
  - `cpu_hold`=1
  - `mem_req`=0
  - `mem_addr`=`BASE_ADDR`
  - `mem_wdata`=0
  - `busy`=0, `done`=0, `error`=0
- `busy`=1 in every state except IDLE, DONE and ERR.
- **Write request:** `mem_req` rises in the cycle after the `rx_valid` of a word's 4th byte. `mem_addr`/`mem_wdata` are stable while `mem_req`=1.
- **Acknowledge:** an ack sampled at edge N drops `mem_req` at N (registered). The minimum request length is 1 cycle if `mem_ack` is already high.
- **Checksum result:** `done`/`error` assert in the cycle after the CHK byte's `rx_valid`. `cpu_hold` falls in the same cycle as `done` rises.
- **Length error:** an oversized LEN → `error` in the cycle after LEN_HI.
- **Simultaneous `rx_valid` and `mem_ack` in WRITE:** the byte goes to pending, the write completes, and no overrun is flagged.

## Test plan
- **Normal load:** send 55 02 00 | 78 56 34 12 | EF BE AD DE | CHK=0x02^(XOR of the data bytes). Expect:
  - write 0x12345678 @0, then 0xDEADBEEF @1;
  - `done`=1, `cpu_hold`=0, `error`=0.
- **Empty frame:** send 55 00 00 00 → `done`=1 with no `mem_req`.
- **Bad checksum:** two-word frame with CHK XOR 0xFF. Expect:
  - both writes occur;
  - `error`=1, `cpu_hold`=1, `done`=0.
- **Backpressure and overrun:**
  - hold `mem_ack`=0 for 3 bytes after a word completes → overrun, `error`=1;
  - with the ack delayed while only 1 byte arrives → no error, and the next word is correct.
- **Timeout and recovery:** after 55 01, stop sending for `TIMEOUT` cycles → `error`=1. Then a full valid frame → `done`=1 and `error`=0.
- **Oversize and reset:**
  - with ADDR_W=4, LEN=0x0011 → `error`;
  - assert `reset` mid-WRITE → `mem_req`=0 and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Boot loader: parses a framed program image from the UART receiver and writes it
// word by word into instruction memory, releasing the CPU only after a clean frame.
module uart_boot_loader #(
    parameter int          ADDR_W    = 12,
    parameter int          BASE_ADDR = 0,
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter int          TIMEOUT   = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [32:0]       MAX_LEN  = 33'd1 << ADDR_W;

    function automatic logic in_frame(input state_t s);
        return (s != S_IDLE) && (s != S_DONE) && (s != S_ERR);
    endfunction

    state_t              state_r, state_n;
    logic [7:0]          len_lo_r, len_lo_n;
    logic [16:0]         words_left_r, words_left_n;
    logic [1:0]          byte_idx_r, byte_idx_n;
    logic [31:0]         wdata_r, wdata_n;
    logic [ADDR_W-1:0]   addr_r, addr_n;
    logic [7:0]          xor_r, xor_n;
    logic [7:0]          pend_r, pend_n;
    logic                pend_vld_r, pend_vld_n;
    logic [CNT_W-1:0]    cnt_r, cnt_n;
    logic                mem_req_r, cpu_hold_r, busy_r, done_r, error_r;
    logic                take_s, overrun_s, tmo_s, frozen_s;
    logic [7:0]          byte_s;

    // A pending byte always takes precedence over the live receiver byte.
    assign byte_s   = pend_vld_r ? pend_r : rx_byte;
    assign take_s   = in_frame(state_r) && (state_r != S_WRITE) && (pend_vld_r || rx_valid);
    assign frozen_s = (state_r == S_WRITE) && pend_vld_r;
    assign tmo_s    = in_frame(state_r) && !rx_valid && !frozen_s && (cnt_r >= TMO_LAST);

    // Next-state, datapath and pending-byte logic.
    always_comb begin
        state_n      = state_r;
        len_lo_n     = len_lo_r;
        words_left_n = words_left_r;
        byte_idx_n   = byte_idx_r;
        wdata_n      = wdata_r;
        addr_n       = addr_r;
        xor_n        = xor_r;
        pend_n       = pend_r;
        pend_vld_n   = pend_vld_r;
        overrun_s    = 1'b0;

        if (rx_valid || !in_frame(state_r)) begin
            cnt_n = '0;
        end else if (frozen_s) begin
            cnt_n = cnt_r;
        end else begin
            cnt_n = cnt_r + CNT_W'(1);
        end

        // One-entry buffer: fills in WRITE, refills if a byte lands while it drains.
        if (state_r == S_WRITE) begin
            if (rx_valid) begin
                if (pend_vld_r) begin
                    overrun_s = 1'b1;
                end else begin
                    pend_vld_n = 1'b1;
                    pend_n     = rx_byte;
                end
            end else begin
                pend_vld_n = pend_vld_r;
            end
        end else if (pend_vld_r && rx_valid) begin
            pend_n     = rx_byte;
            pend_vld_n = 1'b1;
        end else begin
            pend_vld_n = 1'b0;
        end

        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    state_n    = S_LEN_LO;
                    xor_n      = 8'h00;
                    addr_n     = BASE_A;
                    byte_idx_n = 2'd0;
                end else begin
                    state_n = state_r;
                end
            end
            S_LEN_LO: begin
                if (take_s) begin
                    len_lo_n = byte_s;
                    xor_n    = xor_r ^ byte_s;
                    state_n  = S_LEN_HI;
                end else begin
                    state_n = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (take_s) begin
                    xor_n        = xor_r ^ byte_s;
                    words_left_n = {1'b0, byte_s, len_lo_r};
                    byte_idx_n   = 2'd0;
                    if ({17'd0, byte_s, len_lo_r} > MAX_LEN) begin
                        state_n = S_ERR;
                    end else if ({byte_s, len_lo_r} == 16'd0) begin
                        state_n = S_CHK;
                    end else begin
                        state_n = S_DATA;
                    end
                end else begin
                    state_n = S_LEN_HI;
                end
            end
            S_DATA: begin
                if (take_s) begin
                    xor_n      = xor_r ^ byte_s;
                    byte_idx_n = byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0:    wdata_n[7:0]   = byte_s;
                        2'd1:    wdata_n[15:8]  = byte_s;
                        2'd2:    wdata_n[23:16] = byte_s;
                        default: wdata_n[31:24] = byte_s;
                    endcase
                    if (byte_idx_r == 2'd3) begin
                        state_n = S_WRITE;
                    end else begin
                        state_n = S_DATA;
                    end
                end else begin
                    state_n = S_DATA;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    addr_n       = addr_r + ADDR_W'(1);
                    words_left_n = words_left_r - 17'd1;
                    if (words_left_r == 17'd1) begin
                        state_n = S_CHK;
                    end else begin
                        state_n = S_DATA;
                    end
                end else begin
                    state_n = S_WRITE;
                end
            end
            S_CHK: begin
                if (take_s) begin
                    if (byte_s == xor_r) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ERR;
                    end
                end else begin
                    state_n = S_CHK;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (overrun_s || tmo_s) begin
            state_n = S_ERR;
        end else begin
            state_n = state_n;
        end

        if (!in_frame(state_n)) begin
            pend_vld_n = 1'b0;
        end else begin
            pend_vld_n = pend_vld_n;
        end
    end

    // State, datapath and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            len_lo_r     <= 8'h00;
            words_left_r <= 17'd0;
            byte_idx_r   <= 2'd0;
            wdata_r      <= 32'd0;
            addr_r       <= BASE_A;
            xor_r        <= 8'h00;
            pend_r       <= 8'h00;
            pend_vld_r   <= 1'b0;
            cnt_r        <= '0;
            mem_req_r    <= 1'b0;
            cpu_hold_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            len_lo_r     <= len_lo_n;
            words_left_r <= words_left_n;
            byte_idx_r   <= byte_idx_n;
            wdata_r      <= wdata_n;
            addr_r       <= addr_n;
            xor_r        <= xor_n;
            pend_r       <= pend_n;
            pend_vld_r   <= pend_vld_n;
            cnt_r        <= cnt_n;
            mem_req_r    <= (state_n == S_WRITE);
            cpu_hold_r   <= (state_n != S_DONE);
            busy_r       <= in_frame(state_n);
            done_r       <= (state_n == S_DONE);
            error_r      <= (state_n == S_ERR);
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader (ADDR_W=4, short timeout).
module tb_uart_boot_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 40;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    int          checks;
    int          failures;
    int          wr_cnt;
    logic        ack_block;
    logic [31:0] wr_data [64];
    logic [31:0] wr_addr [64];

    uart_boot_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0),
        .SYNC_BYTE (8'h55),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks in the same cycle as the request unless blocked.
    always @(negedge clk) begin
        mem_ack = mem_req && !ack_block;
    end

    // Write logger for completed handshakes.
    always @(posedge clk) begin
        if (!reset && mem_req && mem_ack && wr_cnt < 64) begin
            wr_addr[wr_cnt] = 32'(mem_addr);
            wr_data[wr_cnt] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        pulse(b);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] frame_a [12];
        checks    = 0;
        failures  = 0;
        wr_cnt    = 0;
        ack_block = 1'b0;
        mem_ack   = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        reset     = 1'b1;
        frame_a   = '{8'h55, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};

        repeat (3) @(negedge clk);
        check_eq("rst_hold",  32'(cpu_hold),  32'd1);
        check_eq("rst_req",   32'(mem_req),   32'd0);
        check_eq("rst_addr",  32'(mem_addr),  32'd0);
        check_eq("rst_wdata", mem_wdata,      32'd0);
        check_eq("rst_flags", {29'd0, busy, done, error}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal two-word load
        for (int i = 0; i < 6; i++) send(frame_a[i]);
        check_eq("busy_mid", 32'(busy), 32'd1);
        pulse(8'h12);
        check_eq("req_rise",  32'(mem_req), 32'd1);
        check_eq("req_wdata", mem_wdata,    32'h1234_5678);
        repeat (2) @(negedge clk);
        for (int i = 7; i < 11; i++) send(frame_a[i]);
        pulse(8'h28);
        check_eq("done_timing", {30'd0, done, cpu_hold}, 32'b10);
        repeat (2) @(negedge clk);
        check_eq("norm_cnt",   32'(wr_cnt), 32'd2);
        check_eq("norm_a0",    wr_addr[0],  32'd0);
        check_eq("norm_d0",    wr_data[0],  32'h1234_5678);
        check_eq("norm_a1",    wr_addr[1],  32'd1);
        check_eq("norm_d1",    wr_data[1],  32'hDEAD_BEEF);
        check_eq("norm_flags", {29'd0, busy, error, cpu_hold}, 32'd0);

        // Empty frame, also checks that restart clears done and re-holds the CPU
        pulse(8'h55);
        check_eq("restart", {30'd0, done, cpu_hold}, 32'b01);
        repeat (2) @(negedge clk);
        send(8'h00); send(8'h00); send(8'h00);
        check_eq("empty_done", {29'd0, done, error, cpu_hold}, 32'b100);
        check_eq("empty_cnt",  32'(wr_cnt), 32'd2);

        // Bad checksum: good CHK would be 0x06
        send(8'h55); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0D); send(8'h0C); send(8'h0B); send(8'h0A);
        pulse(8'hF9);
        check_eq("bad_flags", {29'd0, done, error, cpu_hold}, 32'b011);
        check_eq("bad_cnt",   32'(wr_cnt),  32'd4);
        check_eq("bad_d2",    wr_data[2],   32'h0403_0201);
        check_eq("bad_d3",    wr_data[3],   32'h0A0B_0C0D);
        check_eq("bad_a3",    wr_addr[3],   32'd1);
        repeat (2) @(negedge clk);

        // Overrun: ack withheld while bytes keep arriving
        ack_block = 1'b1;
        send(8'h55); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check_eq("bp_req", 32'(mem_req), 32'd1);
        send(8'hA1);
        check_eq("bp_one_ok", 32'(error), 32'd0);
        pulse(8'hA2);
        check_eq("overrun", 32'(error), 32'd1);
        repeat (2) @(negedge clk);
        send(8'hA3);
        check_eq("ovr_state", {30'd0, mem_req, cpu_hold}, 32'b01);
        check_eq("ovr_cnt",   32'(wr_cnt), 32'd4);

        // Delayed ack with a single pending byte
        send(8'h55); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0D);
        repeat (5) @(negedge clk);
        check_eq("pend_hold", {29'd0, mem_req, error, busy}, 32'b101);
        check_eq("pend_wdata", mem_wdata, 32'h0403_0201);
        ack_block = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h0C); send(8'h0B); send(8'h0A);
        send(8'h06);
        check_eq("pend_done", {30'd0, done, error}, 32'b10);
        check_eq("pend_cnt",  32'(wr_cnt),  32'd6);
        check_eq("pend_d4",   wr_data[4],   32'h0403_0201);
        check_eq("pend_d5",   wr_data[5],   32'h0A0B_0C0D);
        check_eq("pend_a5",   wr_addr[5],   32'd1);

        // Timeout after 55 01
        send(8'h55);
        pulse(8'h01);
        repeat (TIMEOUT - 5) @(negedge clk);
        check_eq("tmo_before", {30'd0, busy, error}, 32'b10);
        repeat (10) @(negedge clk);
        check_eq("tmo_after", {29'd0, busy, error, cpu_hold}, 32'b011);

        // Recovery with back-to-back bytes (byte and ack in the same WRITE cycle)
        for (int i = 0; i < 12; i++) pulse(frame_a[i]);
        repeat (4) @(negedge clk);
        check_eq("rec_flags", {29'd0, done, error, cpu_hold}, 32'b100);
        check_eq("rec_cnt",   32'(wr_cnt), 32'd8);
        check_eq("rec_d6",    wr_data[6],  32'h1234_5678);
        check_eq("rec_a6",    wr_addr[6],  32'd0);
        check_eq("rec_d7",    wr_data[7],  32'hDEAD_BEEF);
        check_eq("rec_a7",    wr_addr[7],  32'd1);

        // Oversize length: 17 > 16 words
        send(8'h55); send(8'h11);
        pulse(8'h00);
        check_eq("len_err", {30'd0, busy, error}, 32'b01);
        repeat (2) @(negedge clk);

        // Largest legal length, then reset in the middle of the second write
        send(8'h55); send(8'h10); send(8'h00);
        check_eq("len_max_ok", {30'd0, busy, error}, 32'b10);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        ack_block = 1'b1;
        send(8'h0D); send(8'h0C); send(8'h0B); send(8'h0A);
        check_eq("w2_req",  32'(mem_req),  32'd1);
        check_eq("w2_addr", 32'(mem_addr), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("arst_req",   32'(mem_req),   32'd0);
        check_eq("arst_addr",  32'(mem_addr),  32'd0);
        check_eq("arst_wdata", mem_wdata,      32'd0);
        check_eq("arst_outs",  {28'd0, cpu_hold, busy, done, error}, 32'b1000);
        check_eq("arst_cnt",   32'(wr_cnt),    32'd9);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        ack_block = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
